// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory access controller between the EX/MEM stage and a
//               req/gnt/rvalid bus. Aligns stores and extends loads.
//               Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_ctrl (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] inst_i,
  input  logic        mem_r_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i,
  output logic [31:0] mem_r_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic [29:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;

  logic [2:0]  w_funct3;
  logic        w_rd;
  logic        w_wr;
  logic        w_any;
  logic [31:0] w_addr;
  logic        w_misal_acc;
  logic        w_idle;
  logic        w_start;
  logic        w_busy;
  logic        w_complete;
  logic        w_timeout;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load;
  logic        w_unused_inst;

  assign w_unused_inst = ^{inst_i[31:15], inst_i[11:0]};

  // A simultaneous read and write performs the read only.
  assign w_funct3    = inst_i[14:12];
  assign w_rd        = mem_r_ena_i;
  assign w_wr        = mem_w_ena_i & ~mem_r_ena_i;
  assign w_any       = w_rd | w_wr;
  assign w_addr      = w_rd ? mem_r_addr_i : mem_w_addr_i;
  assign w_misal_acc = ((w_funct3[1:0] == 2'b01) & w_addr[0]) |
                       (w_funct3[1] & (w_addr[1:0] != 2'b00));
  assign w_idle      = (r_state == c_IDLE);
  assign w_start     = w_idle & w_any & ~w_misal_acc;
  assign w_busy      = (r_state == c_REQ) | (r_state == c_WAIT);
  assign w_complete  = ((r_state == c_REQ) & bus_gnt_i) |
                       ((r_state == c_WAIT) & bus_rvalid_i);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_w_data_i;
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{mem_w_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_w_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_w_data_i;
      end
    endcase
    if (!w_wr) begin
      w_wdata = 32'h0;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // The counter reaches 255 on the same edge that forces DONE.
  assign w_timeout = w_busy & (r_cnt == 8'd254) & ~w_complete;
  assign w_err     = r_err;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_start) begin
        r_cnt <= 8'd0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_start) w_state_nxt = c_REQ;
      c_REQ: begin
        if (bus_gnt_i) begin
          w_state_nxt = r_we ? c_DONE : c_WAIT;
        end else if (w_timeout) begin
          w_state_nxt = c_DONE;
        end
      end
      c_WAIT: if (bus_rvalid_i || w_timeout) w_state_nxt = c_DONE;
      c_DONE: w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_addr   <= 30'h0;
      r_we     <= 1'b0;
      r_be     <= 4'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'h0;
      r_off    <= 2'h0;
      r_rdata  <= 32'h0;
    end else begin
      if (w_start) begin
        r_addr   <= w_addr[31:2];
        r_we     <= w_wr;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_funct3 <= w_funct3;
        r_off    <= w_addr[1:0];
      end
      if ((r_state == c_WAIT) && bus_rvalid_i) begin
        r_rdata <= bus_rdata_i;
      end
    end
  end

  always_comb begin
    case (r_off)
      2'd0:    w_ld_byte = r_rdata[7:0];
      2'd1:    w_ld_byte = r_rdata[15:8];
      2'd2:    w_ld_byte = r_rdata[23:16];
      default: w_ld_byte = r_rdata[31:24];
    endcase
    w_ld_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_load = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_load = {24'h0, w_ld_byte};
      3'b101:  w_load = {16'h0, w_ld_half};
      default: w_load = r_rdata;
    endcase
  end

  assign bus_we_o    = r_we;
  assign bus_addr_o  = {r_addr, 2'b00};
  assign bus_be_o    = r_be;
  assign bus_wdata_o = r_wdata;

  // Combinational flags are gated so every output is 0 while reset is held.
  always_comb begin
    stall_o      = arst_n & (w_start | w_busy);
    misalign_o   = arst_n & w_idle & w_any & w_misal_acc;
    bus_req_o    = (r_state == c_REQ);
    err_o        = (r_state == c_DONE) & w_err;
    mem_r_data_o = 32'h0;
    if ((r_state == c_DONE) && !r_we && !w_err) begin
      mem_r_data_o = w_load;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl; checks loads, stores, misalignment,
// reset behaviour and the timeout option.
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        mem_r_ena = 1'b0;
  logic [31:0] mem_r_addr = 32'h0;
  logic        mem_w_ena = 1'b0;
  logic [31:0] mem_w_addr = 32'h0;
  logic [31:0] mem_w_data = 32'h0;
  logic [31:0] mem_r_data;
  logic        stall, misalign, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int n_vec = 0;
  int n_bad = 0;

  int          t_stall;
  logic [31:0] t_data, t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        t_err, t_misal, t_req, t_we, t_unstable, t_tmo;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .inst_i       (inst),
    .mem_r_ena_i  (mem_r_ena),
    .mem_r_addr_i (mem_r_addr),
    .mem_w_ena_i  (mem_w_ena),
    .mem_w_addr_i (mem_w_addr),
    .mem_w_data_i (mem_w_data),
    .mem_r_data_o (mem_r_data),
    .stall_o      (stall),
    .misalign_o   (misalign),
    .err_o        (err),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_be_o     (bus_be),
    .bus_wdata_o  (bus_wdata),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  // Drives one access from IDLE and records what the bus and pipeline saw.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] raddr, input logic [31:0] waddr,
                            input logic [31:0] wdata, input int gnt_delay,
                            input logic [31:0] rdata);
    int   req_cnt;
    logic rv_pending;
    req_cnt = 0; rv_pending = 1'b0;
    t_stall = 0; t_data = '0; t_addr = '0; t_wdata = '0; t_be = '0;
    t_err = 0; t_misal = 0; t_req = 0; t_we = 0; t_unstable = 0; t_tmo = 1;
    @(posedge clk); #1;
    inst = {17'h0, f3, 12'h0};
    mem_r_ena = rd; mem_w_ena = wr;
    mem_r_addr = raddr; mem_w_addr = waddr; mem_w_data = wdata;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (stall) t_stall++;
      if (bus_req) begin
        if (!t_req) begin
          t_addr = bus_addr; t_be = bus_be; t_wdata = bus_wdata; t_we = bus_we;
        end else if (bus_addr !== t_addr || bus_be !== t_be || bus_wdata !== t_wdata) begin
          t_unstable = 1;
        end
        t_req = 1;
        bus_gnt = (req_cnt == gnt_delay);
        if (bus_gnt && !bus_we) rv_pending = 1'b1;
        req_cnt++;
      end else if (rv_pending) begin
        bus_rvalid = 1'b1; bus_rdata = rdata; rv_pending = 1'b0;
      end
      if (!stall) begin
        t_data = mem_r_data; t_err = err; t_misal = misalign; t_tmo = 0;
        break;
      end
      @(posedge clk); #1;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
    end
    @(posedge clk); #1;
    mem_r_ena = 0; mem_w_ena = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    inst = 32'h0000_2000; mem_r_ena = 1; mem_r_addr = 32'h101;
    #3;
    n_vec++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL rst_misalign got %b exp 0", misalign); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall_mis got %b exp 0", stall); end
    mem_r_addr = 32'h100; #1;
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", stall); end
    n_vec++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b exp 0", bus_req); end
    n_vec++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin n_bad++; $display("FAIL rst_bus got %h exp 0", {bus_we, bus_be, bus_addr, bus_wdata}); end
    n_vec++; if (mem_r_data !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 0", mem_r_data); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err); end
    mem_r_ena = 0;
    @(posedge clk); #1; arst_n = 1;
    @(negedge clk);
    n_vec++; if (stall !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_release got %b%b exp 00", stall, bus_req); end
  endtask

  task automatic test_word_load();
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 32'h8765_4321);
    n_vec++; if (t_tmo !== 1'b0) begin n_bad++; $display("FAIL lw_timeout got %b exp 0", t_tmo); end
    n_vec++; if (t_stall !== 3) begin n_bad++; $display("FAIL lw_stall got %0d exp 3", t_stall); end
    n_vec++; if (t_addr !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h exp 00000100", t_addr); end
    n_vec++; if (t_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b exp 1111", t_be); end
    n_vec++; if (t_we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %b exp 0", t_we); end
    n_vec++; if (t_data !== 32'h8765_4321) begin n_bad++; $display("FAIL lw_data got %h exp 87654321", t_data); end
    @(negedge clk);
    n_vec++; if (mem_r_data !== 32'h0) begin n_bad++; $display("FAIL lw_idle_data got %h exp 0", mem_r_data); end
  endtask

  task automatic test_sub_word_loads();
    logic [2:0]  f3[8]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b011, 3'b111, 3'b001};
    logic [31:0] ad[8]  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h104, 32'h108, 32'h100};
    logic [31:0] rd[8]  = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_1234, 32'hBEEF_0000,
                            32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_CAFE, 32'h0000_7FFF};
    logic [31:0] ex[8]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_BEEF,
                            32'h0000_0056, 32'hCAFE_F00D, 32'h0BAD_CAFE, 32'h0000_7FFF};
    logic [3:0]  be[8]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b1111, 4'b1111, 4'b0011};
    for (int i = 0; i < 8; i++) begin
      run_access(1, 0, f3[i], ad[i], 32'h0, 32'h0, 0, rd[i]);
      n_vec++; if (t_data !== ex[i]) begin n_bad++; $display("FAIL load%0d_data got %h exp %h", i, t_data, ex[i]); end
      n_vec++; if (t_be !== be[i]) begin n_bad++; $display("FAIL load%0d_be got %b exp %b", i, t_be, be[i]); end
    end
  endtask

  task automatic test_stores();
    run_access(0, 1, 3'b001, 32'h0, 32'h202, 32'h0000_ABCD, 3, 32'h0);
    n_vec++; if (t_stall !== 5) begin n_bad++; $display("FAIL sh_stall got %0d exp 5", t_stall); end
    n_vec++; if (t_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b exp 1100", t_be); end
    n_vec++; if (t_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata got %h exp abcdabcd", t_wdata); end
    n_vec++; if (t_addr !== 32'h200 || t_we !== 1'b1) begin n_bad++; $display("FAIL sh_addr_we got %h/%b exp 00000200/1", t_addr, t_we); end
    n_vec++; if (t_unstable !== 1'b0) begin n_bad++; $display("FAIL sh_hold got %b exp 0", t_unstable); end
    n_vec++; if (t_data !== 32'h0) begin n_bad++; $display("FAIL sh_rdata got %h exp 0", t_data); end
    run_access(0, 1, 3'b000, 32'h0, 32'h201, 32'h1234_5677, 0, 32'h0);
    n_vec++; if (t_stall !== 2) begin n_bad++; $display("FAIL sb_stall got %0d exp 2", t_stall); end
    n_vec++; if (t_be !== 4'b0010 || t_wdata !== 32'h7777_7777) begin n_bad++; $display("FAIL sb_be_wdata got %b/%h exp 0010/77777777", t_be, t_wdata); end
    run_access(0, 1, 3'b010, 32'h0, 32'h300, 32'hDEAD_BEEF, 0, 32'h0);
    n_vec++; if (t_be !== 4'b1111 || t_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_be_wdata got %b/%h exp 1111/deadbeef", t_be, t_wdata); end
  endtask

  task automatic test_read_over_write();
    run_access(1, 1, 3'b010, 32'h400, 32'h500, 32'h1111_1111, 0, 32'h2468_ACE0);
    n_vec++; if (t_addr !== 32'h400 || t_we !== 1'b0) begin n_bad++; $display("FAIL rw_addr_we got %h/%b exp 00000400/0", t_addr, t_we); end
    n_vec++; if (t_data !== 32'h2468_ACE0 || t_stall !== 3) begin n_bad++; $display("FAIL rw_data got %h/%0d exp 2468ace0/3", t_data, t_stall); end
  endtask

  task automatic test_misalign();
    logic        r[3]  = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  f3[3] = '{3'b010, 3'b001, 3'b101};
    logic [31:0] ad[3] = '{32'h101, 32'h203, 32'h105};
    for (int i = 0; i < 3; i++) begin
      run_access(r[i], ~r[i], f3[i], ad[i], ad[i], 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
      n_vec++; if (t_misal !== 1'b1) begin n_bad++; $display("FAIL mis%0d_flag got %b exp 1", i, t_misal); end
      n_vec++; if (t_req !== 1'b0 || t_stall !== 0 || t_data !== 32'h0) begin n_bad++; $display("FAIL mis%0d_quiet got req=%b stall=%0d data=%h exp 0/0/0", i, t_req, t_stall, t_data); end
    end
    @(negedge clk);
    n_vec++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_clear got %b exp 0", misalign); end
  endtask

  task automatic test_idle_ignore();
    @(posedge clk); #1;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus_req !== 1'b0 || stall !== 1'b0 || mem_r_data !== 32'h0) begin n_bad++; $display("FAIL idle%0d got req=%b stall=%b data=%h exp 0/0/0", i, bus_req, stall, mem_r_data); end
    end
    @(posedge clk); #1;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    inst = 32'h0000_2000; mem_r_ena = 1; mem_r_addr = 32'h100; bus_gnt = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req got %b exp 1", bus_req); end
    @(posedge clk); #1; bus_gnt = 0;
    @(negedge clk);
    n_vec++; if (stall !== 1'b1 || bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_wait got %b%b exp 10", stall, bus_req); end
    #2; arst_n = 0; #1;
    n_vec++; if (stall !== 1'b0 || bus_req !== 1'b0 || bus_addr !== 32'h0) begin n_bad++; $display("FAIL rmid_async got stall=%b req=%b addr=%h exp 0/0/0", stall, bus_req, bus_addr); end
    mem_r_ena = 0;
    @(posedge clk); #1; arst_n = 1;
    @(posedge clk); #1; bus_rvalid = 1; bus_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    n_vec++; if (stall !== 1'b0 || mem_r_data !== 32'h0) begin n_bad++; $display("FAIL rmid_late got stall=%b data=%h exp 0/0", stall, mem_r_data); end
    @(posedge clk); #1; bus_rvalid = 0; bus_rdata = '0;
    @(negedge clk);
    n_vec++; if (mem_r_data !== 32'h0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_after got data=%h req=%b exp 0/0", mem_r_data, bus_req); end
  endtask

  task automatic test_timeout();
`ifdef DMEM_TIMEOUT_EN
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 1000, 32'h0);
    n_vec++; if (t_tmo !== 1'b0) begin n_bad++; $display("FAIL tmo_done got hang exp done"); end
    n_vec++; if (t_stall !== 256) begin n_bad++; $display("FAIL tmo_stall got %0d exp 256", t_stall); end
    n_vec++; if (t_err !== 1'b1 || t_data !== 32'h0) begin n_bad++; $display("FAIL tmo_err got %b/%h exp 1/0", t_err, t_data); end
    @(negedge clk);
    n_vec++; if (err !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL tmo_after got err=%b stall=%b exp 0/0", err, stall); end
`else
    run_access(0, 1, 3'b010, 32'h0, 32'h600, 32'h1357_9BDF, 300, 32'h0);
    n_vec++; if (t_tmo !== 1'b0) begin n_bad++; $display("FAIL notmo_done got hang exp done"); end
    n_vec++; if (t_stall !== 302) begin n_bad++; $display("FAIL notmo_stall got %0d exp 302", t_stall); end
    n_vec++; if (t_err !== 1'b0) begin n_bad++; $display("FAIL notmo_err got %b exp 0", t_err); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_load();
    test_sub_word_loads();
    test_stores();
    test_read_over_write();
    test_misalign();
    test_idle_ignore();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
